// File: rtl/n13_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : n13_frame_loader
// Description : Input stage for the 4x4 n13 AN-decoding array. It takes
//               6-bit AN codewords (A = 13), one per in_valid/in_ready
//               handshake, and packs them row-major into a 16-cell frame.
//               Each complete frame is presented as one 96-bit word. Two
//               frame banks ping-pong, so one bank can fill while the
//               downstream decoder holds the other.
//
// Ports       : clk, rst        - single clock, synchronous active-high reset
//               in_valid/ready  - codeword input handshake
//               in_data [5:0]   - codeword for the next cell
//               in_last         - accepted word closes its frame
//               frame_valid/ready - frame output handshake
//               frame_data [95:0] - cell k at bits [6k+5:6k]
//               frame_padded    - presented frame was closed early
//               frame_err_cnt [4:0] - non-codeword cells in presented frame
//
// Parameter   : PAD_VAL - fill value for cells left empty by an early close
//               (must be a multiple of 13)
//
// Macro       : N13_FRAME_ERRCNT_EN - when defined, every accepted word is
//               checked for in_data mod 13 != 0 and counted per bank.
//               When undefined, frame_err_cnt is tied to zero.
//
// Revision    : 1.0 - initial release
// ============================================================================
module n13_frame_loader #(
    parameter logic [5:0] PAD_VAL = 6'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_data,
    input  logic        in_last,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [95:0] frame_data,
    output logic        frame_padded,
    output logic [4:0]  frame_err_cnt
);

    // Per-bank state encoding
    localparam logic [1:0] c_EMPTY   = 2'd0;
    localparam logic [1:0] c_FILLING = 2'd1;
    localparam logic [1:0] c_FULL    = 2'd2;
    localparam logic [3:0] c_LAST_IDX = 4'd15;

    logic [1:0]  r_state [0:1];
    logic [95:0] r_data  [0:1];
    logic [1:0]  r_pad;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [3:0]  r_wr_idx;

    logic        w_accept;
    logic        w_close;
    logic        w_early;
    logic        w_consume;

    // in_ready depends only on registered state, never on in_valid.
    assign in_ready    = (r_state[r_wr_ptr] != c_FULL);
    assign frame_valid = (r_state[r_rd_ptr] == c_FULL);

    assign w_accept  = in_valid & in_ready;
    assign w_early   = in_last & (r_wr_idx != c_LAST_IDX);
    assign w_close   = w_accept & (in_last | (r_wr_idx == c_LAST_IDX));
    assign w_consume = frame_valid & frame_ready;

    assign frame_data   = r_data[r_rd_ptr];
    assign frame_padded = r_pad[r_rd_ptr];

    // Consume and fill never target the same bank in one cycle: a consume
    // needs the read bank FULL, an accept needs the fill bank not FULL.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state[0] <= c_EMPTY;
            r_state[1] <= c_EMPTY;
            r_data[0]  <= '0;
            r_data[1]  <= '0;
            r_pad      <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_wr_idx   <= '0;
        end else begin
            if (w_consume) begin
                r_state[r_rd_ptr] <= c_EMPTY;
                r_rd_ptr          <= ~r_rd_ptr;
            end
            if (w_accept) begin
                // Write the addressed cell; on an early close every cell
                // above it receives the pad value on the same edge.
                for (int k = 0; k < 16; k++) begin
                    if (4'(k) == r_wr_idx) begin
                        r_data[r_wr_ptr][6*k +: 6] <= in_data;
                    end else if (w_early && (4'(k) > r_wr_idx)) begin
                        r_data[r_wr_ptr][6*k +: 6] <= PAD_VAL;
                    end
                end
                if (w_close) begin
                    r_state[r_wr_ptr] <= c_FULL;
                    r_pad[r_wr_ptr]   <= w_early;
                    r_wr_idx          <= '0;
                    r_wr_ptr          <= ~r_wr_ptr;
                end else begin
                    r_state[r_wr_ptr] <= c_FILLING;
                    r_wr_idx          <= r_wr_idx + 4'd1;
                end
            end
        end
    end

`ifdef N13_FRAME_ERRCNT_EN
    logic [4:0] r_err [0:1];
    logic       w_bad;

    // Constant-divisor modulus over a 6-bit operand: a 64-entry function.
    assign w_bad = ((in_data % 6'd13) != 6'd0);

    // Counter restarts on the first write of a frame; pad cells are never
    // presented here so they cannot count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err[0] <= '0;
            r_err[1] <= '0;
        end else if (w_accept) begin
            r_err[r_wr_ptr] <= ((r_wr_idx == 4'd0) ? 5'd0 : r_err[r_wr_ptr])
                               + {4'd0, w_bad};
        end
    end

    assign frame_err_cnt = r_err[r_rd_ptr];
`else
    assign frame_err_cnt = 5'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_n13_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_n13_frame_loader
// Description : Self-checking bench for n13_frame_loader. Stimulus pushes
//               each expected frame into a scoreboard queue; a forked
//               monitor pops and compares whenever a frame is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_n13_frame_loader;

    localparam logic [5:0] c_PAD = 6'd39;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_data;
    logic        in_last;
    logic        frame_valid;
    logic        frame_ready;
    logic [95:0] frame_data;
    logic        frame_padded;
    logic [4:0]  frame_err_cnt;

    typedef struct packed {
        logic [95:0] data;
        logic        pad;
        logic [4:0]  err;
    } frame_t;

    frame_t      sb[$];
    int          n_err;
    int          n_chk;
    int          stall_cnt;
    logic [95:0] m_data;
    int          m_idx;
    int          m_err;

    n13_frame_loader #(.PAD_VAL(c_PAD)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_data   (frame_data),
        .frame_padded (frame_padded),
        .frame_err_cnt(frame_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_data = '0;
        m_idx  = 0;
        m_err  = 0;
    endtask

    // Drive one word and hold it until accepted; updates the frame model.
    task automatic send(input logic [5:0] d, input logic l);
        logic rdy;
        int   waits;
        waits    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waits++;
            if (waits > 200) begin
                chk("accept_timeout", 96'd0, 96'd1);
                break;
            end
        end
        stall_cnt += waits;
        m_data[6*m_idx +: 6] = d;
`ifdef N13_FRAME_ERRCNT_EN
        if ((d % 6'd13) != 6'd0) m_err++;
`endif
        if (l || m_idx == 15) begin
            for (int k = m_idx + 1; k < 16; k++) m_data[6*k +: 6] = c_PAD;
            sb.push_back('{m_data, (m_idx != 15), 5'(m_err)});
            model_clear();
        end else begin
            m_idx++;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk(name, 96'(sb.size()), 96'd0);
    endtask

    task automatic monitor();
        frame_t e;
        forever begin
            @(negedge clk);
            if (!rst && frame_valid && frame_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 96'd1, 96'd0);
                end else begin
                    e = sb.pop_front();
                    chk("frame_data", frame_data, e.data);
                    chk("frame_padded", 96'(frame_padded), 96'(e.pad));
                    chk("frame_err_cnt", 96'(frame_err_cnt), 96'(e.err));
                end
            end
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        frame_ready = 1'b0; n_err = 0; n_chk = 0; stall_cnt = 0;
        model_clear();
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 96'(in_ready), 96'd1);
        chk("rst_frame_valid", 96'(frame_valid), 96'd0);
        chk("rst_frame_data", frame_data, 96'd0);
        chk("rst_frame_padded", 96'(frame_padded), 96'd0);
        chk("rst_frame_err_cnt", 96'(frame_err_cnt), 96'd0);
        @(posedge clk);
        #1;

        // Full frame 0,13,26,39,52,0,...
        frame_ready = 1'b1;
        for (int i = 0; i < 15; i++) send(6'((i % 5) * 13), 1'b0);
        chk("valid_before_close", 96'(frame_valid), 96'd0);
        send(6'd0, 1'b0);
        chk("valid_after_close", 96'(frame_valid), 96'd1);
        chk("cell0", 96'(frame_data[5:0]), 96'd0);
        chk("cell2", 96'(frame_data[17:12]), 96'd26);
        chk("full_not_padded", 96'(frame_padded), 96'd0);
        chk("full_err_cnt", 96'(frame_err_cnt), 96'd0);
        idle();
        wait_drain("drain_full");

        // Early close after 5 words
        for (int i = 0; i < 5; i++) send(6'd13, (i == 4));
        chk("early_padded", 96'(frame_padded), 96'd1);
        chk("early_cell4", 96'(frame_data[29:24]), 96'd13);
        chk("early_cell5_pad", 96'(frame_data[35:30]), 96'(c_PAD));
        chk("early_cell15_pad", 96'(frame_data[95:90]), 96'(c_PAD));
        idle();
        wait_drain("drain_early");

        // Backpressure: 40 words with frame_ready low
        frame_ready = 1'b0;
        for (int i = 0; i < 32; i++) send(6'((i * 13) % 64), 1'b0);
        chk("bp_in_ready_low", 96'(in_ready), 96'd0);
        in_data = 6'((32 * 13) % 64);
        in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready_held", 96'(in_ready), 96'd0);
        chk("bp_frame_valid", 96'(frame_valid), 96'd1);
        chk("bp_frame_stable", frame_data, sb[0].data);
        frame_ready = 1'b1;
        @(posedge clk);
        #1 frame_ready = 1'b0;
        chk("bp_in_ready_after_pulse", 96'(in_ready), 96'd1);
        for (int i = 32; i < 40; i++) send(6'((i * 13) % 64), (i == 39));
        idle();
        frame_ready = 1'b1;
        wait_drain("drain_bp");

        // Continuous 48-word stream, no bubbles
        stall_cnt = 0;
        for (int i = 0; i < 48; i++) send(6'((i * 5 + 3) % 64), 1'b0);
        idle();
        chk("stream_no_stall", 96'(stall_cnt), 96'd0);
        wait_drain("drain_stream");

        // Reset mid-frame with a held full frame
        frame_ready = 1'b0;
        for (int i = 0; i < 23; i++) send(6'(i + 1), 1'b0);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        model_clear();
        chk("midrst_frame_valid", 96'(frame_valid), 96'd0);
        chk("midrst_in_ready", 96'(in_ready), 96'd1);
        frame_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(6'(63 - i), 1'b0);
        idle();
        wait_drain("drain_midrst");

        // Non-codeword cells 3 and 9
        for (int i = 0; i < 16; i++)
            send((i == 3) ? 6'd14 : (i == 9) ? 6'd27 : 6'((i % 4) * 13), 1'b0);
`ifdef N13_FRAME_ERRCNT_EN
        chk("errcnt_two", 96'(frame_err_cnt), 96'd2);
`else
        chk("errcnt_zero", 96'(frame_err_cnt), 96'd0);
`endif
        idle();
        wait_drain("drain_final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
